// File: rtl/ex_stage_md_if.sv
// Bundle of every non-clock signal between the ID/EX boundary, the execute stage and EX/MEM.
// No latency; the interface is wiring only.
// Backpressure travels as stall_in (toward EX) and md_stall (toward ID/EX).
interface ex_stage_md_if #(
   parameter int WIDTH  = 32,
   parameter int REG_W  = 5,
   parameter int CTRL_W = 10
);
   // ID/EX side
   logic              in_valid;
   logic [WIDTH-1:0]  a_operand;
   logic [WIDTH-1:0]  b_operand;
   logic [WIDTH-1:0]  imm_ext;
   logic [WIDTH-1:0]  pc_plus4;
   logic [WIDTH-1:0]  fwd_mem;
   logic [WIDTH-1:0]  fwd_wb;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic              alu_src;
   logic              reg_dest;
   logic [REG_W-1:0]  dest_rd;
   logic [REG_W-1:0]  dest_rt;
   logic [4:0]        alu_sel;
   logic [CTRL_W-1:0] ctrl_in;
   logic              stall_in;
   // EX/MEM and hazard-unit side
   logic [WIDTH-1:0]  alu_out;
   logic [WIDTH-1:0]  data_to_write;
   logic [REG_W-1:0]  reg_to_write;
   logic [WIDTH-1:0]  pc_plus4_o;
   logic [CTRL_W-1:0] ctrl_out;
   logic              out_valid;
   logic              md_busy;
   logic              md_stall;
   logic [REG_W-1:0]  dest_hz;

   // Driver of the instruction stream (pipeline control / testbench)
   modport master (
      output in_valid, a_operand, b_operand, imm_ext, pc_plus4, fwd_mem, fwd_wb,
             fwd_a_sel, fwd_b_sel, alu_src, reg_dest, dest_rd, dest_rt, alu_sel,
             ctrl_in, stall_in,
      input  alu_out, data_to_write, reg_to_write, pc_plus4_o, ctrl_out, out_valid,
             md_busy, md_stall, dest_hz
   );

   // The execute stage itself
   modport slave (
      input  in_valid, a_operand, b_operand, imm_ext, pc_plus4, fwd_mem, fwd_wb,
             fwd_a_sel, fwd_b_sel, alu_src, reg_dest, dest_rd, dest_rt, alu_sel,
             ctrl_in, stall_in,
      output alu_out, data_to_write, reg_to_write, pc_plus4_o, ctrl_out, out_valid,
             md_busy, md_stall, dest_hz
   );
endinterface

// File: rtl/ex_stage_md.sv
// MIPS execute stage: forwarding, ALU, EX/MEM register and iterative mul/div with HI/LO.
// One cycle to EX/MEM; mul/div runs WIDTH cycles in the background, HI/LO written on the last.
// stall_in freezes EX/MEM (not the mul/div); md_stall holds ID/EX only for dependent HI/LO ops.
module ex_stage_md #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int REG_W   = 5,
   parameter int CTRL_W  = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   ex_stage_md_if.slave bus
);

   localparam logic [4:0] OP_SLL   = 5'd0;
   localparam logic [4:0] OP_SRL   = 5'd1;
   localparam logic [4:0] OP_SRA   = 5'd2;
   localparam logic [4:0] OP_SLLV  = 5'd3;
   localparam logic [4:0] OP_SRLV  = 5'd4;
   localparam logic [4:0] OP_SRAV  = 5'd5;
   localparam logic [4:0] OP_ADD   = 5'd6;
   localparam logic [4:0] OP_SUB   = 5'd7;
   localparam logic [4:0] OP_AND   = 5'd8;
   localparam logic [4:0] OP_OR    = 5'd9;
   localparam logic [4:0] OP_XOR   = 5'd10;
   localparam logic [4:0] OP_NOR   = 5'd11;
   localparam logic [4:0] OP_SLT   = 5'd12;
   localparam logic [4:0] OP_LUI   = 5'd13;
   localparam logic [4:0] OP_LINK  = 5'd14;
   localparam logic [4:0] OP_SLTU  = 5'd15;
   localparam logic [4:0] OP_MULT  = 5'd16;
   localparam logic [4:0] OP_MULTU = 5'd17;
   localparam logic [4:0] OP_DIV   = 5'd18;
   localparam logic [4:0] OP_DIVU  = 5'd19;
   localparam logic [4:0] OP_MFHI  = 5'd20;
   localparam logic [4:0] OP_MFLO  = 5'd21;

   localparam logic [SHAMT_W:0] CNT_INIT = (SHAMT_W+1)'(WIDTH);
   localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);

   // ---------------- combinational datapath ----------------
   logic [WIDTH-1:0]   src_a, src_b, op_b, alu_res;
   logic [SHAMT_W-1:0] shamt_imm, shamt_var;
   logic [REG_W-1:0]   dest;
   logic               is_md_op, is_md_any, md_stall, md_start;

   // ---------------- EX/MEM register ----------------
   logic [WIDTH-1:0]  alu_out_q, alu_out_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [REG_W-1:0]  reg_q, reg_d;
   logic [WIDTH-1:0]  pc_q, pc_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              vld_q, vld_d;

   // ---------------- multiply/divide state ----------------
   // acc holds the running high half (mult) or partial remainder (div);
   // mq holds the multiplier shifting out / the dividend shifting out and quotient shifting in.
   logic [WIDTH-1:0]   acc_q, acc_d, mq_q, mq_d, mcand_q, mcand_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [SHAMT_W:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d, is_div_q, is_div_d;
   logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

   logic               signed_op, start_div, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   acc_step, mq_step;
   logic [2*WIDTH-1:0] prod, prod_fix;

   // Forwarding muxes: 1x takes the EX/MEM result, 01 takes WB, 00 the register file
   always_comb begin
      src_a = bus.a_operand;
      if (bus.fwd_a_sel[1])      src_a = bus.fwd_mem;
      else if (bus.fwd_a_sel[0]) src_a = bus.fwd_wb;
      src_b = bus.b_operand;
      if (bus.fwd_b_sel[1])      src_b = bus.fwd_mem;
      else if (bus.fwd_b_sel[0]) src_b = bus.fwd_wb;
      op_b = bus.alu_src ? bus.imm_ext : src_b;
   end

   assign shamt_imm = bus.imm_ext[6 +: SHAMT_W];
   assign shamt_var = src_a[SHAMT_W-1:0];

   // LINK always writes the last register (r31 for the 5-bit file)
   assign dest = (bus.alu_sel == OP_LINK) ? '1 : (bus.reg_dest ? bus.dest_rd : bus.dest_rt);

   // ALU proper; mul/div codes produce 0 here, their results come back via MFHI/MFLO
   always_comb begin
      alu_res = '0;
      case (bus.alu_sel)
         OP_SLL:  alu_res = op_b << shamt_imm;
         OP_SRL:  alu_res = op_b >> shamt_imm;
         OP_SRA:  alu_res = $signed(op_b) >>> shamt_imm;
         OP_SLLV: alu_res = op_b << shamt_var;
         OP_SRLV: alu_res = op_b >> shamt_var;
         OP_SRAV: alu_res = $signed(op_b) >>> shamt_var;
         OP_ADD:  alu_res = src_a + op_b;
         OP_SUB:  alu_res = src_a - op_b;
         OP_AND:  alu_res = src_a & op_b;
         OP_OR:   alu_res = src_a | op_b;
         OP_XOR:  alu_res = src_a ^ op_b;
         OP_NOR:  alu_res = ~(src_a | op_b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(op_b))};
         OP_LUI:  alu_res = op_b << (WIDTH/2);
         OP_LINK: alu_res = bus.pc_plus4;
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < op_b)};
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         default: alu_res = '0;
      endcase
   end

   // Only instructions touching the mul/div unit or HI/LO wait for it; the completion
   // cycle still counts as busy so MFHI/MFLO pick up the freshly written HI/LO next cycle.
   assign is_md_op  = (bus.alu_sel >= OP_MULT) && (bus.alu_sel <= OP_DIVU);
   assign is_md_any = (bus.alu_sel >= OP_MULT) && (bus.alu_sel <= OP_MFLO);
   assign md_stall  = bus.in_valid & busy_q & is_md_any;
   assign md_start  = bus.in_valid & is_md_op & ~md_stall & ~bus.stall_in;

   // EX/MEM next state: hold under stall_in, bubble under md_stall, else load
   always_comb begin
      alu_out_d = alu_out_q;
      data_d    = data_q;
      reg_d     = reg_q;
      pc_d      = pc_q;
      ctrl_d    = ctrl_q;
      vld_d     = vld_q;
      if (!bus.stall_in) begin
         if (md_stall) begin
            alu_out_d = '0;
            data_d    = '0;
            reg_d     = '0;
            pc_d      = '0;
            ctrl_d    = '0;
            vld_d     = 1'b0;
         end else begin
            alu_out_d = alu_res;
            data_d    = src_b;
            reg_d     = dest;
            pc_d      = bus.pc_plus4;
            ctrl_d    = bus.in_valid ? bus.ctrl_in : '0;
            vld_d     = bus.in_valid;
         end
      end
   end

   // EX/MEM register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_q <= '0;
         data_q    <= '0;
         reg_q     <= '0;
         pc_q      <= '0;
         ctrl_q    <= '0;
         vld_q     <= 1'b0;
      end else begin
         alu_out_q <= alu_out_d;
         data_q    <= data_d;
         reg_q     <= reg_d;
         pc_q      <= pc_d;
         ctrl_q    <= ctrl_d;
         vld_q     <= vld_d;
      end
   end

   // Signed ops run on magnitudes; the sign is re-applied when HI/LO are written
   assign signed_op = (bus.alu_sel == OP_MULT) || (bus.alu_sel == OP_DIV);
   assign start_div = (bus.alu_sel == OP_DIV) || (bus.alu_sel == OP_DIVU);
   assign a_neg     = signed_op & src_a[WIDTH-1];
   assign b_neg     = signed_op & src_b[WIDTH-1];
   assign a_mag     = a_neg ? -src_a : src_a;
   assign b_mag     = b_neg ? -src_b : src_b;

   // One radix-2 step: shift-add for multiply, restoring subtract for divide
   assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
   assign div_shift = {acc_q, mq_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, mcand_q});

   always_comb begin
      if (is_div_q) begin
         acc_step = div_ge ? (div_shift[WIDTH-1:0] - mcand_q) : div_shift[WIDTH-1:0];
         mq_step  = {mq_q[WIDTH-2:0], div_ge};
      end else begin
         acc_step = mul_sum[WIDTH:1];
         mq_step  = {mul_sum[0], mq_q[WIDTH-1:1]};
      end
   end

   assign prod     = {acc_step, mq_step};
   assign prod_fix = neg_lo_q ? -prod : prod;

   // Mul/div next state: start captures operands, each busy cycle steps, the last writes HI/LO.
   // A zero divisor skips sign handling so the plain unsigned loop yields LO=all-ones, HI=dividend.
   always_comb begin
      acc_d    = acc_q;
      mq_d     = mq_q;
      mcand_d  = mcand_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      if (md_start) begin
         is_div_d = start_div;
         cnt_d    = CNT_INIT;
         busy_d   = 1'b1;
         acc_d    = '0;
         if (start_div && (src_b == '0)) begin
            mq_d     = src_a;
            mcand_d  = '0;
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
         end else begin
            mq_d     = a_mag;
            mcand_d  = b_mag;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
         end
      end else if (busy_q) begin
         acc_d = acc_step;
         mq_d  = mq_step;
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            busy_d = 1'b0;
            if (is_div_q) begin
               lo_d = neg_lo_q ? -mq_step : mq_step;
               hi_d = neg_hi_q ? -acc_step : acc_step;
            end else begin
               lo_d = prod_fix[WIDTH-1:0];
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
            end
         end
      end
   end

   // Mul/div registers; reset aborts any iteration in flight and clears HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mq_q     <= '0;
         mcand_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mq_q     <= mq_d;
         mcand_q  <= mcand_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
      end
   end

   assign bus.alu_out       = alu_out_q;
   assign bus.data_to_write = data_q;
   assign bus.reg_to_write  = reg_q;
   assign bus.pc_plus4_o    = pc_q;
   assign bus.ctrl_out      = ctrl_q;
   assign bus.out_valid     = vld_q;
   assign bus.md_busy       = busy_q;
   assign bus.md_stall      = md_stall;
   assign bus.dest_hz       = dest;

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: a 32-bit instance for most steps and a 16-bit one for MULTU.
// Inputs change 1ns after the rising edge; outputs are sampled at that point too.
// Expected values are hand-computed constants.
module tb_ex_stage_md;

   localparam logic [4:0] SLL = 5'd0, SRA = 5'd2, SRAV = 5'd5, ADD = 5'd6, SUB = 5'd7,
                          SLT = 5'd12, LUI = 5'd13, LINK = 5'd14, SLTU = 5'd15,
                          MULT = 5'd16, MULTU = 5'd17, DIV = 5'd18, DIVU = 5'd19,
                          MFHI = 5'd20, MFLO = 5'd21;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n;
   int   bad;

   ex_stage_md_if #(.WIDTH(32), .REG_W(5), .CTRL_W(10)) b32 ();
   ex_stage_md_if #(.WIDTH(16), .REG_W(5), .CTRL_W(10)) b16 ();

   ex_stage_md #(.WIDTH(32), .SHAMT_W(5), .REG_W(5), .CTRL_W(10)) u32 (
      .clk(clk), .rst_n(rst_n), .bus(b32.slave));
   ex_stage_md #(.WIDTH(16), .SHAMT_W(4), .REG_W(5), .CTRL_W(10)) u16 (
      .clk(clk), .rst_n(rst_n), .bus(b16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b32.in_valid  = 1'b0;  b32.a_operand = '0;    b32.b_operand = '0;
      b32.imm_ext   = '0;    b32.pc_plus4  = '0;    b32.fwd_mem   = '0;
      b32.fwd_wb    = '0;    b32.fwd_a_sel = 2'b00; b32.fwd_b_sel = 2'b00;
      b32.alu_src   = 1'b0;  b32.reg_dest  = 1'b1;  b32.dest_rd   = 5'd3;
      b32.dest_rt   = 5'd4;  b32.alu_sel   = ADD;   b32.ctrl_in   = 10'h3FF;
      b32.stall_in  = 1'b0;
      #1;
   endtask

   task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
      idle();
      b32.in_valid  = 1'b1;
      b32.alu_sel   = sel;
      b32.a_operand = a;
      b32.b_operand = b;
      b32.pc_plus4  = 32'h100;
      b32.ctrl_in   = 10'h155;
      #1;
   endtask

   // Present an HI/LO reader and let it wait out the mul/div unit, bounded
   task automatic wait_md();
      for (int i = 0; i < 40; i++) begin
         if (!b32.md_stall) break;
         tick();
      end
      chk("md_wait_bound", {31'd0, b32.md_stall}, 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle();
      b16.in_valid = 1'b0; b16.a_operand = '0; b16.b_operand = '0; b16.imm_ext = '0;
      b16.pc_plus4 = '0;   b16.fwd_mem = '0;   b16.fwd_wb = '0;    b16.fwd_a_sel = 2'b00;
      b16.fwd_b_sel = 2'b00; b16.alu_src = 1'b0; b16.reg_dest = 1'b0; b16.dest_rd = '0;
      b16.dest_rt = '0;    b16.alu_sel = ADD;  b16.ctrl_in = '0;   b16.stall_in = 1'b0;

      // Reset state
      #12;
      chk("rst_out_valid", {31'd0, b32.out_valid}, 32'd0);
      chk("rst_alu_out", b32.alu_out, 32'd0);
      chk("rst_ctrl_out", {22'd0, b32.ctrl_out}, 32'd0);
      chk("rst_md_busy", {31'd0, b32.md_busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1. Reset in the middle of MULT 7*6
      issue(MULT, 32'd7, 32'd6);
      tick();
      chk("t1_busy_rise", {31'd0, b32.md_busy}, 32'd1);
      issue(ADD, 32'd1, 32'd2);
      repeat (9) tick();
      chk("t1_pre_rst_alu", b32.alu_out, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("t1_rst_alu_out", b32.alu_out, 32'd0);
      chk("t1_rst_valid", {31'd0, b32.out_valid}, 32'd0);
      chk("t1_rst_reg", {27'd0, b32.reg_to_write}, 32'd0);
      chk("t1_rst_pc", b32.pc_plus4_o, 32'd0);
      chk("t1_rst_busy", {31'd0, b32.md_busy}, 32'd0);
      #1 rst_n = 1'b1;
      issue(MFLO, 32'd0, 32'd0);
      tick();
      chk("t1_lo_cleared", b32.alu_out, 32'd0);
      chk("t1_mflo_valid", {31'd0, b32.out_valid}, 32'd1);
      issue(MFHI, 32'd0, 32'd0);
      tick();
      chk("t1_hi_cleared", b32.alu_out, 32'd0);
      chk("t1_busy_stays_low", {31'd0, b32.md_busy}, 32'd0);

      // 2. MULT -3*5 then MFLO / MFHI
      issue(MULT, 32'hFFFF_FFFD, 32'd5);
      tick();
      chk("t2_mult_advances", {31'd0, b32.out_valid}, 32'd1);
      chk("t2_mult_alu_zero", b32.alu_out, 32'd0);
      issue(MFLO, 32'd0, 32'd0);
      n = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (!b32.md_stall) break;
         n++;
         tick();
         if (b32.out_valid !== 1'b0) bad++;
      end
      chk("t2_stall_cycles", n, 32'd32);
      chk("t2_bubbles", bad, 32'd0);
      tick();
      chk("t2_mflo", b32.alu_out, 32'hFFFF_FFF1);
      issue(MFHI, 32'd0, 32'd0);
      tick();
      chk("t2_mfhi", b32.alu_out, 32'hFFFF_FFFF);

      // 3. DIV -7/2 with an independent ADD overlapping
      issue(DIV, 32'hFFFF_FFF9, 32'd2);
      tick();
      issue(ADD, 32'd10, 32'd20);
      chk("t3_add_no_stall", {31'd0, b32.md_stall}, 32'd0);
      tick();
      chk("t3_add_result", b32.alu_out, 32'd30);
      chk("t3_store_data", b32.data_to_write, 32'd20);
      chk("t3_add_dest", {27'd0, b32.reg_to_write}, 32'd3);
      chk("t3_still_busy", {31'd0, b32.md_busy}, 32'd1);
      issue(MFLO, 32'd0, 32'd0);
      wait_md();
      tick();
      chk("t3_div_lo", b32.alu_out, 32'hFFFF_FFFD);
      issue(MFHI, 32'd0, 32'd0);
      tick();
      chk("t3_div_hi", b32.alu_out, 32'hFFFF_FFFF);

      // 4. Divide-by-zero and MIN / -1
      issue(DIVU, 32'h1234, 32'd0);
      tick();
      issue(MFLO, 32'd0, 32'd0);
      wait_md();
      tick();
      chk("t4_div0_lo", b32.alu_out, 32'hFFFF_FFFF);
      issue(MFHI, 32'd0, 32'd0);
      tick();
      chk("t4_div0_hi", b32.alu_out, 32'h1234);
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      tick();
      issue(MFLO, 32'd0, 32'd0);
      wait_md();
      tick();
      chk("t4_min_lo", b32.alu_out, 32'h8000_0000);
      issue(MFHI, 32'd0, 32'd0);
      tick();
      chk("t4_min_hi", b32.alu_out, 32'd0);

      // 5. Forwarding, shifts, compares
      issue(SRAV, 32'h1F, 32'hF000_0000);
      b32.fwd_a_sel = 2'b10; b32.fwd_mem = 32'h8000_0000;
      tick();
      chk("t5_srav_fwd_mem", b32.alu_out, 32'hF000_0000);
      issue(SRA, 32'd0, 32'h8000_0000);
      b32.imm_ext = 32'h100;
      tick();
      chk("t5_sra4", b32.alu_out, 32'hF800_0000);
      issue(SLL, 32'd0, 32'd1);
      b32.imm_ext = 32'h140;
      tick();
      chk("t5_sll5", b32.alu_out, 32'h20);
      issue(SLTU, 32'd1, 32'hFFFF_FFFF);
      tick();
      chk("t5_sltu", b32.alu_out, 32'd1);
      issue(SLT, 32'd1, 32'hFFFF_FFFF);
      tick();
      chk("t5_slt", b32.alu_out, 32'd0);
      issue(LUI, 32'd0, 32'd0);
      b32.alu_src = 1'b1; b32.imm_ext = 32'h1234;
      tick();
      chk("t5_lui", b32.alu_out, 32'h1234_0000);
      issue(SUB, 32'd99, 32'd3);
      b32.fwd_a_sel = 2'b01; b32.fwd_wb = 32'd10;
      b32.fwd_b_sel = 2'b10; b32.fwd_mem = 32'd4;
      b32.reg_dest = 1'b0;
      tick();
      chk("t5_sub_fwd", b32.alu_out, 32'd6);
      chk("t5_fwd_store", b32.data_to_write, 32'd4);
      chk("t5_dest_rt", {27'd0, b32.reg_to_write}, 32'd4);
      idle();
      tick();
      chk("t5_invalid_ctrl", {22'd0, b32.ctrl_out}, 32'd0);
      chk("t5_invalid_vld", {31'd0, b32.out_valid}, 32'd0);

      // 6. stall_in hold around LINK
      issue(ADD, 32'd1, 32'd1);
      b32.reg_dest = 1'b0;
      tick();
      chk("t6_pre_add", b32.alu_out, 32'd2);
      issue(LINK, 32'd5, 32'd6);
      b32.pc_plus4 = 32'h40; b32.stall_in = 1'b1;
      #1;
      chk("t6_dest_hz", {27'd0, b32.dest_hz}, 32'd31);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (b32.alu_out !== 32'd2 || b32.reg_to_write !== 5'd4 || b32.pc_plus4_o !== 32'h100) bad++;
      end
      chk("t6_hold", bad, 32'd0);
      b32.stall_in = 1'b0;
      tick();
      chk("t6_link_alu", b32.alu_out, 32'h40);
      chk("t6_link_reg", {27'd0, b32.reg_to_write}, 32'd31);
      chk("t6_link_ctrl", {22'd0, b32.ctrl_out}, 32'h155);
      idle();

      // 6b. WIDTH=16 MULTU 0xFFFF * 0xFFFF
      b16.in_valid = 1'b1; b16.alu_sel = MULTU;
      b16.a_operand = 16'hFFFF; b16.b_operand = 16'hFFFF;
      tick();
      b16.in_valid = 1'b0; b16.alu_sel = ADD;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (!b16.md_busy) break;
         n++;
         tick();
      end
      chk("t6_w16_busy_cycles", n, 32'd16);
      b16.in_valid = 1'b1; b16.alu_sel = MFHI;
      tick();
      chk("t6_w16_hi", {16'd0, b16.alu_out}, 32'hFFFE);
      b16.alu_sel = MFLO;
      tick();
      chk("t6_w16_lo", {16'd0, b16.alu_out}, 32'h0001);
      b16.in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised execute stage for the pipelined MIPS core. It sits between the ID/EX and EX/MEM boundaries.
- Provides operand forwarding muxes, an ALU generic in data width, a registered EX/MEM output bundle with downstream hold, and an iterative multiply/divide unit with HI/LO registers.
- Raises a dependence-only interlock toward the hazard unit while the multiply/divide unit is busy.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, >= 8.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).
- REG_W, 5, register-address width.
- CTRL_W, 10, width of the opaque control bundle passed to MEM/WB.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EX holds a real instruction.
- a_operand  in  WIDTH  rs value from the register file.
- b_operand  in  WIDTH  rt value from the register file.
- imm_ext  in  WIDTH  extended immediate.
- pc_plus4  in  WIDTH  PC+4 of the instruction.
- fwd_mem  in  WIDTH  EX/MEM ALU result, forwarded.
- fwd_wb  in  WIDTH  WB result, forwarded.
- fwd_a_sel  in  2  00 a_operand, 01 fwd_wb, 1x fwd_mem.
- fwd_b_sel  in  2  same encoding, applied to b_operand.
- alu_src  in  1  1 selects imm_ext as operand B.
- reg_dest  in  1  1 selects dest_rd, 0 selects dest_rt.
- dest_rd  in  REG_W  rd field.
- dest_rt  in  REG_W  rt field.
- alu_sel  in  5  operation code, listed under Behaviour.
- ctrl_in  in  CTRL_W  control bits for later stages.
- stall_in  in  1  downstream hold.
- alu_out  out  WIDTH  registered result.
- data_to_write  out  WIDTH  registered forwarded B, used as store data.
- reg_to_write  out  REG_W  registered destination register.
- pc_plus4_o  out  WIDTH  registered PC+4.
- ctrl_out  out  CTRL_W  registered control bundle.
- out_valid  out  1  registered valid.
- md_busy  out  1  multiply/divide iteration in progress.
- md_stall  out  1  combinational; upstream must hold ID/EX this cycle.
- dest_hz  out  REG_W  combinational destination register, for the hazard unit.

Behaviour:
- Reset (rst_n low, asynchronous): every registered output goes to 0. HI, LO, the iteration counter and md_busy go to 0. Reset asserted mid-iteration aborts the operation; HI/LO stay 0.
- Operand selection:
  - srcA = forward mux on a_operand.
  - srcB = forward mux on b_operand.
  - opB = alu_src ? imm_ext : srcB.
- Destination: all-ones if alu_sel = LINK; otherwise reg_dest ? dest_rd : dest_rt. dest_hz carries this value.
- alu_sel codes (result is combinational, WIDTH bits):
  - 0 SLL: opB << imm_ext[6+:SHAMT_W].
  - 1 SRL: logical right shift, same shift amount.
  - 2 SRA: arithmetic right shift (sign-filled), same shift amount.
  - 3 SLLV, 4 SRLV, 5 SRAV: as 0–2, shift amount srcA[SHAMT_W-1:0].
  - 6 ADD and 7 SUB: modulo 2^WIDTH, no overflow trap.
  - 8 AND, 9 OR, 10 XOR, 11 NOR.
  - 12 SLT: signed compare, result 1 or 0.
  - 13 LUI: opB << WIDTH/2.
  - 14 LINK: result = pc_plus4.
  - 15 SLTU: unsigned compare.
  - 16 MULT, 17 MULTU, 18 DIV, 19 DIVU: multiply/divide ops; ALU result 0.
  - 20 MFHI: result = HI.
  - 21 MFLO: result = LO.
  - Any other code: result 0.
- md_stall = in_valid & md_busy & (alu_sel in 16..21). Independent instructions proceed while md_busy is high.
- Output register update:
  - stall_in=1: all outputs hold.
  - Else if md_stall: load a bubble (out_valid=0, ctrl_out=0, other fields 0).
  - Else: load the computed values; out_valid = in_valid.
  - Invalid instructions load ctrl_out = 0.
- Multiply/divide start: on a clock edge with in_valid=1, alu_sel in 16..19, md_stall=0 and stall_in=0.
  - Capture operands and latch the signedness.
  - Load counter = WIDTH; md_busy rises on that edge.
  - The instruction also advances as a normal entry.
- Iteration:
  - One radix-2 step per cycle; counter decrements.
  - On the edge where the counter goes 1 -> 0: write HI/LO and clear md_busy.
  - md_busy is therefore high for exactly WIDTH cycles.
  - stall_in does not pause the iteration.
- Multiply results: HI:LO = full 2*WIDTH-bit product; signed or unsigned per op.
- Divide results: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - Divisor 0: LO = all-ones, HI = dividend.
  - Signed MIN / -1: LO = MIN, HI = 0.
- MFHI/MFLO in EX during the completion cycle: stalled that cycle. Accepted the next cycle, seeing the new HI/LO.

Test Plan:
1. Reset mid-MULT: WIDTH=32; MULT with srcA=7, srcB=6; pulse rst_n low at busy cycle 10 -> all outputs 0, md_busy 0, HI=LO=0 immediately (asynchronous).
2. MULT with srcA=-3, srcB=5, then MFLO next cycle; WIDTH=32:
   - md_stall=1 and out_valid=0 for 32 cycles.
   - Then alu_out = 0xFFFFFFF1.
   - A following MFHI returns 0xFFFFFFFF.
3. DIV with srcA=-7, srcB=2; ADD issued during busy; then MFLO and MFHI:
   - ADD passes with no stall.
   - LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
4. DIVU with srcB=0 and srcA=0x1234 -> LO = 0xFFFFFFFF, HI = 0x1234. DIV with 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
5. Forwarding and shifts:
   - fwd_a_sel=10, fwd_mem=0x80000000, SRAV with srcB=0xF0000000 -> variable shift amount 0, result 0xF0000000.
   - SRA with shift amount 4 on opB=0x80000000 -> 0xF8000000.
   - SLTU with 1 vs 0xFFFFFFFF -> 1.
   - SLT with the same operands -> 0.
6. stall_in=1 for 3 cycles during LINK with pc_plus4=0x40 -> outputs hold; afterwards reg_to_write=31, alu_out=0x40. Repeat with WIDTH=16 and MULTU 0xFFFF * 0xFFFF -> HI=0xFFFE, LO=0x0001, md_busy high 16 cycles.
